// File: rtl/core_fetch_prefetch.sv
// rtl/core_fetch_prefetch.sv - instruction prefetch queue between the bus fetch port and decode
//
// Fetches sequential instruction words over a single-outstanding read bus
// and buffers up to DEPTH of them, each tagged with its word address. The
// oldest buffered word is presented to decode. A flush redirects fetching
// to a new target and discards everything queued or still in flight.
//
// Optional feature macro: PREFETCH_ABORT_EN
//   When defined, each response carries a fault bit (bus_fault). A faulting
//   word is flagged on insn_abort when it reaches the head, and no further
//   requests are issued until the next flush.
//
// Ports:
//   clk         in   1   core clock
//   rst_n       in   1   asynchronous active-low reset
//   flush       in   1   redirect: drop queued and in-flight data, refetch from target
//   target      in   30  word address to fetch after a flush
//   stall       in   1   decode does not consume the head this cycle
//   bus_start   out  1   read request, held until bus_ready
//   bus_addr    out  30  word address of the outstanding request
//   bus_ready   in   1   read data valid this cycle; ends the request
//   bus_data    in   32  read data
//   bus_fault   in   1   (PREFETCH_ABORT_EN) response is faulting
//   insn        out  32  head instruction word
//   insn_pc     out  30  word address of insn
//   insn_valid  out  1   head is valid (queue not empty and no flush)
//   insn_abort  out  1   (PREFETCH_ABORT_EN) head word faulted
module core_fetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [29:0] target,
  input  logic        stall,
  output logic        bus_start,
  output logic [29:0] bus_addr,
  input  logic        bus_ready,
  input  logic [31:0] bus_data,
`ifdef PREFETCH_ABORT_EN
  input  logic        bus_fault,
  output logic        insn_abort,
`endif
  output logic [31:0] insn,
  output logic [29:0] insn_pc,
  output logic        insn_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state;
  logic [29:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   data_mem [DEPTH];
  logic [29:0]   pc_mem   [DEPTH];
  logic          push;
  logic          pop;
  logic          can_start;

`ifdef PREFETCH_ABORT_EN
  logic [DEPTH-1:0] fault_mem;
  logic             abort_hold;

  // A faulting word stops prefetching until decode redirects us.
  assign can_start  = (count < FULL) && !abort_hold;
  assign insn_abort = fault_mem[rd_ptr] & insn_valid;
`else
  assign can_start  = (count < FULL);
`endif

  // flush masks the head in the same cycle so decode never sees a stale word.
  assign insn_valid = (count != '0) && !flush;
  assign insn       = data_mem[rd_ptr];
  assign insn_pc    = pc_mem[rd_ptr];

  // Only a response to a live (non-dropped) request is queued; flush wins.
  assign push = (state == S_WAIT) && bus_ready && !flush;
  assign pop  = insn_valid && !stall;

  // Fetch sequencer. bus_start/bus_addr are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bus_start <= 1'b0;
      bus_addr  <= '0;
      fetch_pc  <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          bus_addr <= fetch_pc;
          if (flush) begin
            fetch_pc <= target;
          end else if (can_start) begin
            state     <= S_WAIT;
            bus_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush) begin
            fetch_pc <= target;
            if (bus_ready) begin
              state     <= S_IDLE;
              bus_start <= 1'b0;
            end else begin
              // The bus cannot cancel; keep the request up and discard its data.
              state <= S_DROP;
            end
          end else if (bus_ready) begin
            fetch_pc  <= fetch_pc + 30'd1;
            state     <= S_IDLE;
            bus_start <= 1'b0;
          end
        end
        S_DROP: begin
          if (flush) begin
            fetch_pc <= target;
          end
          if (bus_ready) begin
            state     <= S_IDLE;
            bus_start <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus_start <= 1'b0;
        end
      endcase
    end
  end

  // Word queue. Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
`ifdef PREFETCH_ABORT_EN
      fault_mem  <= '0;
      abort_hold <= 1'b0;
`endif
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= wr_ptr;
`ifdef PREFETCH_ABORT_EN
      abort_hold <= 1'b0;
`endif
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= bus_data;
        pc_mem[wr_ptr]   <= bus_addr;
        wr_ptr           <= wr_ptr + PTR_ONE;
`ifdef PREFETCH_ABORT_EN
        fault_mem[wr_ptr] <= bus_fault;
        if (bus_fault) begin
          abort_hold <= 1'b1;
        end
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (!push && pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule
